// File: rtl/if_id.sv
// IF/ID pipeline register with an optional 2-entry skid FIFO and a flush that can also drop one late fetch beat.
// Build option: define IF_ID_SKID_BUFFER_EN to add the skid FIFO. Without it, if_ready follows the ID stage directly.
module if_id (
    input  logic        clk,
    input  logic        rst,
    input  logic        flush,
    input  logic        if_valid,
    input  logic [31:0] if_pc,
    input  logic [31:0] if_inst,
    input  logic [31:0] if_except_type,
    input  logic        if_pc_valid,
    input  logic        if_inflight,
    input  logic        id_ready,
    output logic        if_ready,
    output logic        id_valid,
    output logic [31:0] id_pc,
    output logic [31:0] id_inst,
    output logic [31:0] id_except_type,
    output logic        id_pc_valid
);

    typedef struct packed {
        logic [31:0] pc;
        logic [31:0] inst;
        logic [31:0] except_type;
        logic        pc_valid;
    } beat_t;

    // Handshake: a beat moves on a cycle where valid && ready are both high; ready never depends
    // on valid, and a producer holds its beat unchanged until it is taken.
    beat_t in_beat;
    beat_t out_q, out_d;
    beat_t head;
    logic  id_valid_q, id_valid_d;
    logic  drop_q, drop_d;
    logic  advance;
    logic  accept;
    logic  pop;
    logic  bypass;

    assign in_beat = '{pc: if_pc, inst: if_inst, except_type: if_except_type, pc_valid: if_pc_valid};
    assign advance = !id_valid_q || id_ready;
    assign accept  = if_valid && if_ready && !flush && !drop_q;

`ifdef IF_ID_SKID_BUFFER_EN
    logic [1:0] count_q, count_d;
    logic       wr_ptr_q, wr_ptr_d;
    logic       rd_ptr_q, rd_ptr_d;
    logic       push;
    beat_t      mem_q [2];

    // While a late beat is being dropped it is always consumed, even with the FIFO full.
    assign if_ready = !flush && (drop_q || (count_q < 2'd2));
    assign pop      = advance && (count_q != 2'd0);
    assign bypass   = advance && (count_q == 2'd0) && accept;
    assign push     = accept && !bypass;
    assign head     = mem_q[rd_ptr_q];

    always_comb begin
        count_d  = count_q;
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        if (flush) begin
            count_d  = 2'd0;
            wr_ptr_d = 1'b0;
            rd_ptr_d = 1'b0;
        end else begin
            if (push) wr_ptr_d = wr_ptr_q + 1'b1;
            if (pop)  rd_ptr_d = rd_ptr_q + 1'b1;
            case ({push, pop})
                2'b10:   count_d = count_q + 2'd1;
                2'b01:   count_d = count_q - 2'd1;
                default: count_d = count_q;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            count_q  <= 2'd0;
            wr_ptr_q <= 1'b0;
            rd_ptr_q <= 1'b0;
        end else begin
            count_q  <= count_d;
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
        end
    end

    // Storage needs no reset: count_q alone decides which entries are live.
    always_ff @(posedge clk) begin
        if (push) mem_q[wr_ptr_q] <= in_beat;
    end
`else
    assign if_ready = !flush && (drop_q || advance);
    assign pop      = 1'b0;
    assign bypass   = advance && accept;
    assign head     = '0;
`endif

    always_comb begin
        id_valid_d = id_valid_q;
        out_d      = out_q;
        if (flush) begin
            id_valid_d = 1'b0;
            out_d      = '0;
        end else if (advance) begin
            if (pop) begin
                id_valid_d = 1'b1;
                out_d      = head;
            end else if (bypass) begin
                id_valid_d = 1'b1;
                out_d      = in_beat;
            end else begin
                id_valid_d = 1'b0;
                out_d      = '0;
            end
        end
    end

    // A repeated flush must not forget a late beat that is still owed.
    always_comb begin
        drop_d = drop_q;
        if (flush) begin
            drop_d = drop_q || if_inflight;
        end else if (drop_q && if_valid) begin
            drop_d = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            id_valid_q <= 1'b0;
            out_q      <= '0;
            drop_q     <= 1'b0;
        end else begin
            id_valid_q <= id_valid_d;
            out_q      <= out_d;
            drop_q     <= drop_d;
        end
    end

    assign id_valid       = id_valid_q;
    assign id_pc          = out_q.pc;
    assign id_inst        = out_q.inst;
    assign id_except_type = out_q.except_type;
    assign id_pc_valid    = out_q.pc_valid;

endmodule

// File: tb/tb_if_id.sv
// Directed bench for if_id: a streaming vector table plus hand sequences for stall, flush and reset.
module tb_if_id;

    logic        clk = 1'b0;
    logic        rst;
    logic        flush;
    logic        if_valid;
    logic [31:0] if_pc;
    logic [31:0] if_inst;
    logic [31:0] if_except_type;
    logic        if_pc_valid;
    logic        if_inflight;
    logic        id_ready;
    logic        if_ready;
    logic        id_valid;
    logic [31:0] id_pc;
    logic [31:0] id_inst;
    logic [31:0] id_except_type;
    logic        id_pc_valid;

    int total = 0;
    int bad   = 0;

    typedef struct {
        logic        v;
        logic [31:0] pc;
        logic [31:0] inst;
        logic [31:0] exc;
        logic        pcv;
        logic        e_valid;
        logic [31:0] e_pc;
        logic [31:0] e_inst;
        logic [31:0] e_exc;
        logic        e_pcv;
    } vec_t;

    vec_t vecs [7];

    if_id dut (
        .clk            (clk),
        .rst            (rst),
        .flush          (flush),
        .if_valid       (if_valid),
        .if_pc          (if_pc),
        .if_inst        (if_inst),
        .if_except_type (if_except_type),
        .if_pc_valid    (if_pc_valid),
        .if_inflight    (if_inflight),
        .id_ready       (id_ready),
        .if_ready       (if_ready),
        .id_valid       (id_valid),
        .id_pc          (id_pc),
        .id_inst        (id_inst),
        .id_except_type (id_except_type),
        .id_pc_valid    (id_pc_valid)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h want %h", name, act, exp);
        end
    endtask

    task automatic chk_out(input string name, input logic ev, input logic [31:0] epc);
        chk({name, ".valid"}, {31'd0, id_valid}, {31'd0, ev});
        chk({name, ".pc"}, id_pc, ev ? epc : 32'd0);
        chk({name, ".inst"}, id_inst, ev ? ~epc : 32'd0);
        chk({name, ".exc"}, id_except_type, 32'd0);
        chk({name, ".pcv"}, {31'd0, id_pc_valid}, {31'd0, ev});
    endtask

    task automatic chk_rdy(input string name, input logic exp);
        #1;
        chk({name, ".if_ready"}, {31'd0, if_ready}, {31'd0, exp});
    endtask

    task automatic set_in(input logic v, input logic [31:0] pc, input logic idr,
                          input logic fl, input logic infl);
        if_valid       = v;
        if_pc          = pc;
        if_inst        = ~pc;
        if_except_type = 32'd0;
        if_pc_valid    = 1'b1;
        id_ready       = idr;
        flush          = fl;
        if_inflight    = infl;
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Leaves 0x80000000 held on id_* with id_ready low; with the skid FIFO, 0x..04 and 0x..08 queued.
    task automatic fill(input string name);
        set_in(1'b1, 32'h8000_0000, 1'b1, 1'b0, 1'b0);
        tick();
        chk_out({name, ".first"}, 1'b1, 32'h8000_0000);
`ifdef IF_ID_SKID_BUFFER_EN
        set_in(1'b1, 32'h8000_0004, 1'b0, 1'b0, 1'b0);
        chk_rdy({name, ".push1"}, 1'b1);
        tick();
        chk_out({name, ".hold1"}, 1'b1, 32'h8000_0000);
        set_in(1'b1, 32'h8000_0008, 1'b0, 1'b0, 1'b0);
        chk_rdy({name, ".push2"}, 1'b1);
        tick();
        chk_out({name, ".hold2"}, 1'b1, 32'h8000_0000);
        set_in(1'b0, 32'h0, 1'b0, 1'b0, 1'b0);
        chk_rdy({name, ".full"}, 1'b0);
`else
        set_in(1'b1, 32'h8000_0004, 1'b0, 1'b0, 1'b0);
        chk_rdy({name, ".stalled"}, 1'b0);
        tick();
        chk_out({name, ".hold"}, 1'b1, 32'h8000_0000);
`endif
    endtask

    initial begin
        vecs[0] = '{1'b1, 32'hBFC0_0000, 32'h2402_0001, 32'h0, 1'b1,
                    1'b1, 32'hBFC0_0000, 32'h2402_0001, 32'h0, 1'b1};
        vecs[1] = '{1'b1, 32'hBFC0_0004, 32'h2403_0002, 32'h0, 1'b1,
                    1'b1, 32'hBFC0_0004, 32'h2403_0002, 32'h0, 1'b1};
        vecs[2] = '{1'b1, 32'hBFC0_0008, 32'h0043_1020, 32'h0, 1'b1,
                    1'b1, 32'hBFC0_0008, 32'h0043_1020, 32'h0, 1'b1};
        vecs[3] = '{1'b1, 32'hBFC0_000C, 32'h0000_0000, 32'h0000_0010, 1'b0,
                    1'b1, 32'hBFC0_000C, 32'h0000_0000, 32'h0000_0010, 1'b0};
        vecs[4] = '{1'b0, 32'h1234_5678, 32'h9ABC_DEF0, 32'h0000_0004, 1'b1,
                    1'b0, 32'h0, 32'h0, 32'h0, 1'b0};
        vecs[5] = '{1'b1, 32'h8000_0100, 32'h8C01_0000, 32'h0000_0004, 1'b1,
                    1'b1, 32'h8000_0100, 32'h8C01_0000, 32'h0000_0004, 1'b1};
        vecs[6] = '{1'b0, 32'h0, 32'h0, 32'h0, 1'b0,
                    1'b0, 32'h0, 32'h0, 32'h0, 1'b0};

        rst = 1'b1;
        set_in(1'b0, 32'h0, 1'b0, 1'b0, 1'b0);
        tick();
        tick();
        rst = 1'b0;
        chk_out("reset", 1'b0, 32'h0);
        chk_rdy("reset", 1'b1);

        // Streaming with id_ready high: each beat appears on id_* one edge later.
        for (int i = 0; i < 7; i++) begin
            if_valid       = vecs[i].v;
            if_pc          = vecs[i].pc;
            if_inst        = vecs[i].inst;
            if_except_type = vecs[i].exc;
            if_pc_valid    = vecs[i].pcv;
            id_ready       = 1'b1;
            flush          = 1'b0;
            if_inflight    = 1'b0;
            chk_rdy($sformatf("vec%0d", i), 1'b1);
            tick();
            chk($sformatf("vec%0d.valid", i), {31'd0, id_valid}, {31'd0, vecs[i].e_valid});
            chk($sformatf("vec%0d.pc", i), id_pc, vecs[i].e_pc);
            chk($sformatf("vec%0d.inst", i), id_inst, vecs[i].e_inst);
            chk($sformatf("vec%0d.exc", i), id_except_type, vecs[i].e_exc);
            chk($sformatf("vec%0d.pcv", i), {31'd0, id_pc_valid}, {31'd0, vecs[i].e_pcv});
        end

        // Stall, then release: beats come out in acceptance order.
        fill("stall");
`ifdef IF_ID_SKID_BUFFER_EN
        set_in(1'b0, 32'h0, 1'b1, 1'b0, 1'b0);
        tick();
        chk_out("release1", 1'b1, 32'h8000_0004);
        tick();
        chk_out("release2", 1'b1, 32'h8000_0008);
        chk_rdy("release2", 1'b1);
`else
        set_in(1'b1, 32'h8000_0004, 1'b1, 1'b0, 1'b0);
        chk_rdy("release1", 1'b1);
        tick();
        chk_out("release1", 1'b1, 32'h8000_0004);
        set_in(1'b1, 32'h8000_0008, 1'b1, 1'b0, 1'b0);
        tick();
        chk_out("release2", 1'b1, 32'h8000_0008);
        set_in(1'b0, 32'h0, 1'b1, 1'b0, 1'b0);
`endif
        tick();
        chk_out("drained", 1'b0, 32'h0);

        // Flush with a fetch in flight: the next beat is dropped, the one after is presented.
        fill("fl_inf");
        set_in(1'b0, 32'h0, 1'b0, 1'b1, 1'b1);
        chk_rdy("fl_inf.flush", 1'b0);
        tick();
        chk_out("fl_inf.killed", 1'b0, 32'h0);
        set_in(1'b1, 32'h8000_0010, 1'b1, 1'b0, 1'b0);
        chk_rdy("fl_inf.drop", 1'b1);
        tick();
        chk_out("fl_inf.dropped", 1'b0, 32'h0);
        set_in(1'b1, 32'hBFC0_0380, 1'b1, 1'b0, 1'b0);
        tick();
        chk_out("fl_inf.next", 1'b1, 32'hBFC0_0380);
        set_in(1'b0, 32'h0, 1'b1, 1'b0, 1'b0);
        tick();
        chk_out("fl_inf.empty", 1'b0, 32'h0);

        // Second flush while a drop is pending: still exactly one beat dropped.
        set_in(1'b1, 32'h8000_0040, 1'b1, 1'b1, 1'b1);
        tick();
        chk_out("dbl.flush1", 1'b0, 32'h0);
        set_in(1'b0, 32'h0, 1'b1, 1'b1, 1'b0);
        tick();
        chk_out("dbl.flush2", 1'b0, 32'h0);
        set_in(1'b1, 32'h8000_0044, 1'b1, 1'b0, 1'b0);
        tick();
        chk_out("dbl.dropped", 1'b0, 32'h0);
        set_in(1'b1, 32'h8000_0048, 1'b1, 1'b0, 1'b0);
        tick();
        chk_out("dbl.next", 1'b1, 32'h8000_0048);
        set_in(1'b0, 32'h0, 1'b1, 1'b0, 1'b0);
        tick();

        // Flush without a fetch in flight: the first beat afterwards is presented.
        set_in(1'b1, 32'h8000_0050, 1'b1, 1'b1, 1'b0);
        tick();
        chk_out("fl_noinf.killed", 1'b0, 32'h0);
        set_in(1'b1, 32'h8000_0054, 1'b1, 1'b0, 1'b0);
        chk_rdy("fl_noinf.next", 1'b1);
        tick();
        chk_out("fl_noinf.next", 1'b1, 32'h8000_0054);
        set_in(1'b0, 32'h0, 1'b1, 1'b0, 1'b0);
        tick();

        // Reset mid-stall dominates a simultaneous flush with fetch in flight.
        fill("rst_stall");
        rst = 1'b1;
        set_in(1'b0, 32'h0, 1'b0, 1'b1, 1'b1);
        tick();
        rst = 1'b0;
        set_in(1'b0, 32'h0, 1'b0, 1'b0, 1'b0);
        chk_out("rst_stall.cleared", 1'b0, 32'h0);
        chk_rdy("rst_stall", 1'b1);
        set_in(1'b1, 32'h8000_0060, 1'b1, 1'b0, 1'b0);
        tick();
        chk_out("rst_stall.next", 1'b1, 32'h8000_0060);
        set_in(1'b0, 32'h0, 1'b1, 1'b0, 1'b0);
        tick();
        chk_out("rst_stall.empty", 1'b0, 32'h0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
